// File: rtl/base_arb_pkg.sv
// Shared types and helpers for the base valid/ready arbiter family.
package base_arb_pkg;

    // Upper bounds for the width-agnostic helper functions below.
    localparam int unsigned MAX_WAYS  = 64;
    localparam int unsigned MAX_WBITS = 32;

    // Arbitration decision for the current cycle.
    typedef enum logic [1:0] {
        SEL_IDLE = 2'd0,  // nobody eligible, output idle
        SEL_LOCK = 2'd1,  // owner holds the grant through a packet
        SEL_STAY = 2'd2,  // owner still inside its weighted tenure
        SEL_ROT  = 2'd3   // hand the grant to the next requester
    } sel_e;

    // Index of the set bit in a one-hot vector (0 when no bit is set).
    function automatic int unsigned oh2idx(input logic [MAX_WAYS-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned k = 0; k < MAX_WAYS; k++) begin
            if (oh[k]) idx = k;
        end
        return idx;
    endfunction

    // Increment that sticks at 2^w-1 for a w-bit counter.
    function automatic logic [MAX_WBITS-1:0] sat_inc(input logic [MAX_WBITS-1:0] v,
                                                     input int unsigned       w);
        logic [MAX_WBITS-1:0] top;
        top = (w >= MAX_WBITS) ? '1 : ((MAX_WBITS'(1) << w) - MAX_WBITS'(1));
        return (v >= top) ? v : v + MAX_WBITS'(1);
    endfunction

endpackage

// File: rtl/base_arr_rr_pick.sv
// Round-robin pick: first requester strictly after owner g, wrapping, ending at g.
module base_arr_rr_pick #(
    parameter int unsigned ways = 4
) (
    input  logic [ways-1:0] i_v,
    input  logic [ways-1:0] i_g,
    output logic [ways-1:0] o_pick
);

    logic [ways-1:0]   w_above;
    logic [2*ways-1:0] w_dbl;
    logic [2*ways-1:0] w_dbl_gnt;

    // Mask of ways with index above the owner; empty when g is the top way.
    assign w_above = ~((i_g << 1) - ways'(1));

    // Lower copy holds ways after g, upper copy supplies the wrap-around back to g.
    assign w_dbl = {i_v, i_v & w_above};

    base_prienc_hp #(
        .W (2*ways)
    ) u_pe (
        .i_req (w_dbl),
        .o_gnt (w_dbl_gnt)
    );

    // Fold both halves back onto way positions; at most one half is non-zero.
    assign o_pick = w_dbl_gnt[ways-1:0] | w_dbl_gnt[2*ways-1:ways];

endmodule

// File: rtl/base_prienc_hp.sv
// Priority encoder, lowest index wins, one-hot result (all-zero when idle).
module base_prienc_hp #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_req,
    output logic [W-1:0] o_gnt
);

    // Two's-complement trick isolates the lowest set bit.
    assign o_gnt = i_req & (~i_req + W'(1));

endmodule

// File: rtl/base_vlat_en.sv
// Enabled register with synchronous active-high reset to a constant.
module base_vlat_en #(
    parameter int unsigned  W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Load on enable; reset wins over enable.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every register samples pre-edge values.
        if (reset) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/base_arr_arb_wrr.sv
// Weighted round-robin valid/ready arbiter with packet hold.
module base_arr_arb_wrr
    import base_arb_pkg::*;
#(
    parameter int unsigned ways  = 4,
    parameter int unsigned wbits = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ways*wbits-1:0] i_wt,
    input  logic [ways-1:0]       i_v,
    input  logic [ways-1:0]       i_h,
    output logic [ways-1:0]       i_r,
    input  logic                  o_r,
    output logic                  o_v,
    output logic [ways-1:0]       o_s,
    output logic                  o_h
);

    // Owner resets to the top way so way 0 is first in line after reset.
    localparam logic [ways-1:0] G_RST = ways'(1) << (ways - 1);

    logic [ways-1:0]  w_g;
    logic [wbits-1:0] w_cnt;
    logic             w_lck;

    logic [ways-1:0]  w_pick;
    logic [ways-1:0]  w_win;
    logic [wbits-1:0] w_wt_g;
    logic             w_own_v;
    int unsigned      w_g_idx;
    sel_e             w_sel;

    logic             w_act;
    logic             w_cont;
    logic [ways-1:0]  w_g_d;
    logic [wbits-1:0] w_cnt_d;
    logic             w_lck_d;

    base_arr_rr_pick #(
        .ways (ways)
    ) u_pick (
        .i_v    (i_v),
        .i_g    (w_g),
        .o_pick (w_pick)
    );

    // Winner selection: lock, weighted stay, or rotate to the next requester.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_sel   = SEL_IDLE;
        w_win   = '0;
        w_wt_g  = '0;
        w_g_idx = oh2idx(MAX_WAYS'(w_g));
        w_own_v = |(w_g & i_v);

        for (int unsigned k = 0; k < ways; k++) begin
            if (w_g_idx == k) w_wt_g = i_wt[k*wbits +: wbits];
        end

        if (w_lck) begin
            w_sel = SEL_LOCK;
            w_win = w_own_v ? w_g : '0;
        end else if (w_own_v && (w_cnt < w_wt_g)) begin
            w_sel = SEL_STAY;
            w_win = w_g;
        end else if (|w_pick) begin
            w_sel = SEL_ROT;
            w_win = w_pick;
        end
    end

    // Stream outputs; valid is never gated by downstream ready.
    always_comb begin
        o_s = w_win;
        o_v = |w_win;
        o_h = |(w_win & i_h);
        i_r = {ways{o_r}} & w_win;
    end

    // Next state, applied only when a beat is actually accepted.
    always_comb begin
        w_act   = o_v & o_r;
        w_cont  = (w_sel == SEL_LOCK) || (w_sel == SEL_STAY);
        w_g_d   = w_cont ? w_g : w_win;
        w_cnt_d = w_cont ? wbits'(sat_inc(MAX_WBITS'(w_cnt), wbits)) : '0;
        w_lck_d = o_h;
    end

    base_vlat_en #(
        .W       (ways),
        .RST_VAL (G_RST)
    ) u_g (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_act),
        .i_d   (w_g_d),
        .o_q   (w_g)
    );

    base_vlat_en #(
        .W       (wbits),
        .RST_VAL ('0)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_act),
        .i_d   (w_cnt_d),
        .o_q   (w_cnt)
    );

    base_vlat_en #(
        .W       (1),
        .RST_VAL (1'b0)
    ) u_lck (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_act),
        .i_d   (w_lck_d),
        .o_q   (w_lck)
    );

endmodule

// File: tb/tb_base_arr_arb_wrr.sv
// Directed self-checking bench for base_arr_arb_wrr (ways=4, wbits=2).
module tb_base_arr_arb_wrr;

    localparam int unsigned WAYS  = 4;
    localparam int unsigned WBITS = 2;

    logic                   clk;
    logic                   reset;
    logic [WAYS*WBITS-1:0]  i_wt;
    logic [WAYS-1:0]        i_v;
    logic [WAYS-1:0]        i_h;
    logic [WAYS-1:0]        i_r;
    logic                   o_r;
    logic                   o_v;
    logic [WAYS-1:0]        o_s;
    logic                   o_h;

    int n_chk;
    int n_fail;

    base_arr_arb_wrr #(
        .ways  (WAYS),
        .wbits (WBITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .i_wt  (i_wt),
        .i_v   (i_v),
        .i_h   (i_h),
        .i_r   (i_r),
        .o_r   (o_r),
        .o_v   (o_v),
        .o_s   (o_s),
        .o_h   (o_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when it differs.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs just after a rising edge, then wait for the falling edge to sample.
    task automatic drive(input logic [3:0] v, input logic [3:0] h, input logic r);
        i_v = v;
        i_h = h;
        o_r = r;
        @(negedge clk);
    endtask

    // Let the rising edge commit state, then move off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_v   = '0;
        i_h   = '0;
        o_r   = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Expected winners for the weighted sequence, way 0 in bit 0.
    logic [3:0] exp_wrr [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100,
                                 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001};
    logic [3:0] exp_rr  [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        i_wt   = '0;
        i_v    = '0;
        i_h    = '0;
        o_r    = 1'b0;
        tick();
        do_reset();

        // Reset state with no requests.
        drive(4'b0000, 4'b0000, 1'b1);
        check("rst_o_v", o_v, 1'b0);
        check("rst_o_s", o_s, 4'b0000);
        check("rst_o_h", o_h, 1'b0);
        check("rst_i_r", i_r, 4'b0000);
        check("rst_lck", dut.w_lck, 1'b0);
        tick();

        // Plain round robin with zero weights.
        i_wt = '0;
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b0000, 1'b1);
            check($sformatf("rr_o_s_%0d", i), o_s, exp_rr[i]);
            check($sformatf("rr_i_r_%0d", i), i_r, exp_rr[i]);
            tick();
        end

        // Weighted: way0 weight 2 (3 beats), way3 weight 1 (2 beats).
        do_reset();
        i_wt = {2'd1, 2'd0, 2'd0, 2'd2};
        for (int i = 0; i < 10; i++) begin
            drive((i == 0) ? 4'b0001 : 4'b1111, 4'b0000, 1'b1);
            check($sformatf("wrr_o_s_%0d", i), o_s, exp_wrr[i]);
            tick();
        end

        // Packet hold: way 1 keeps the grant for 3 beats despite zero weight.
        do_reset();
        i_wt = '0;
        drive(4'b0010, 4'b0010, 1'b1);
        check("hold_o_s_0", o_s, 4'b0010);
        check("hold_o_h_0", o_h, 1'b1);
        tick();
        drive(4'b1110, 4'b0010, 1'b1);
        check("hold_o_s_1", o_s, 4'b0010);
        check("hold_o_h_1", o_h, 1'b1);
        check("hold_i_r_1", i_r, 4'b0010);
        tick();
        drive(4'b1110, 4'b0000, 1'b1);
        check("hold_o_s_2", o_s, 4'b0010);
        check("hold_o_h_2", o_h, 1'b0);
        check("hold_i_r_2", i_r, 4'b0010);
        tick();
        drive(4'b1110, 4'b0000, 1'b1);
        check("hold_o_s_3", o_s, 4'b0100);
        tick();

        // Locked owner drops valid: output stalls, other ways never granted.
        do_reset();
        drive(4'b0001, 4'b0001, 1'b1);
        check("lock_o_s_0", o_s, 4'b0001);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(4'b0100, 4'b0000, 1'b1);
            check($sformatf("lock_stall_o_v_%0d", i), o_v, 1'b0);
            check($sformatf("lock_stall_o_s_%0d", i), o_s, 4'b0000);
            tick();
        end
        drive(4'b0101, 4'b0000, 1'b1);
        check("lock_ret_o_s", o_s, 4'b0001);
        check("lock_ret_i_r", i_r, 4'b0001);
        tick();
        check("lock_rel_lck", dut.w_lck, 1'b0);
        drive(4'b0101, 4'b0000, 1'b1);
        check("lock_next_o_s", o_s, 4'b0100);
        tick();

        // Backpressure: grant stable, no ready, state frozen.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'b0110, 4'b0000, 1'b0);
            check($sformatf("bp_o_v_%0d", i), o_v, 1'b1);
            check($sformatf("bp_o_s_%0d", i), o_s, 4'b0010);
            check($sformatf("bp_i_r_%0d", i), i_r, 4'b0000);
            tick();
            check($sformatf("bp_g_%0d", i), dut.w_g, 4'b1000);
            check($sformatf("bp_cnt_%0d", i), dut.w_cnt, 2'd0);
        end
        drive(4'b0110, 4'b0000, 1'b1);
        check("bp_acc_i_r", i_r, 4'b0010);
        tick();
        check("bp_acc_g", dut.w_g, 4'b0010);

        // Reset while way 3 holds a lock: arbitration restarts at way 0.
        do_reset();
        drive(4'b1000, 4'b1000, 1'b1);
        check("rlk_o_s", o_s, 4'b1000);
        tick();
        check("rlk_lck_set", dut.w_lck, 1'b1);
        reset = 1'b1;
        i_v   = 4'b1111;
        i_h   = 4'b0000;
        tick();
        reset = 1'b0;
        drive(4'b1111, 4'b0000, 1'b1);
        check("rlk_o_s_after", o_s, 4'b0001);
        check("rlk_lck_after", dut.w_lck, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/base_arr_arb_wrr.md
Name: base_arr_arb_wrr

Overview:
- Parametrised weighted round-robin arbiter with packet hold, next generation of the base valid/ready arbiters.
- Merges `ways` valid/ready input streams onto one output stream.
- A winner keeps the grant for up to weight+1 consecutive accepted beats (per-way runtime weight); it also keeps the grant while it asserts hold.
- Sits in front of shared buses and queues where bursty sources need bandwidth shares but packets must not interleave.

Parameters:
ways, 4, number of requesting inputs (>=1)
wbits, 4, width of each per-way weight and of the tenure counter

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
i_wt  input  ways*wbits  per-way weight, way k in bits [k*wbits:(k+1)*wbits-1]; may change any cycle
i_v  input  ways  per-way request valid, bit 0 = way 0
i_h  input  ways  per-way hold: keep grant after this beat
i_r  output  ways  per-way ready (beat accepted when i_v[k] & i_r[k])
o_r  input  1  downstream ready
o_v  output  1  output valid
o_s  output  ways  one-hot select of winning way, all-zero when o_v=0
o_h  output  1  hold of winning beat forwarded downstream

Behaviour:
- State registers:
  - g: one-hot owner of current tenure.
  - cnt: wbits, extra beats already taken in this tenure.
  - lck: 1 bit.
- Reset (synchronous, active-high):
  - g=way ways-1, cnt=0, lck=0, so way 0 has first priority after reset.
  - Outputs are combinational from state and inputs; with i_v=0 after reset: o_v=0, o_s=0, o_h=0, i_r=0.
- Winner selection (combinational, zero latency):
  - lck=1: candidate is g only. o_v=i_v[g]. If the owner drops valid, output stalls; other ways are never granted.
  - lck=0, i_v[g]=1 and cnt<wt[g]: stay, winner=g.
  - Otherwise rotate: first valid way scanning g+1, g+2 … wrapping, ending at g. g is re-won only if it is the sole requester.
  - No valid requester: o_v=0, o_s=0.
- Outputs:
  - o_s = winner one-hot.
  - o_h = |(o_s & i_h).
  - i_r[k] = o_r & o_s[k].
  - o_v is never gated by o_r.
- Update only on act = o_v & o_r:
  - Stay or locked continuation: cnt <= cnt+1, saturating at 2^wbits-1.
  - Rotate (including re-winning g): g <= winner, cnt <= 0.
  - lck <= i_h[winner].
  - No act: all state holds, so o_s is stable under backpressure.
- Weight semantics:
  - wt=0 gives plain round robin, 1 beat per tenure.
  - wt=n gives up to n+1 beats.
  - Held beats count toward cnt. On release, if cnt>=wt[g], the next beat rotates.
  - A weight change applies to the comparison in the same cycle.
- Boundary cases:
  - i_h on a non-accepted cycle has no effect.
  - i_v[g] dropping while unlocked and cnt<wt: rotate immediately, the tenure is forfeited.
  - Reset mid-lock clears the lock; the next cycle arbitrates from way 0.
  - ways=1: winner is always way 0; weights and cnt are irrelevant but legal.

Decomposition:
- Package base_arb_pkg: function for the one-hot-to-index helper; wbits-wide saturating increment function.
- Sub-module base_arr_rr_pick (combinational): given i_v and one-hot g, returns the one-hot next requester after g with wrap. Built with the doubled-vector trick on base_prienc_hp.
- State registers use base_vlat_en enabled by act.

Test Plan (ways=4, wbits=2):
1. Reset, then i_v=1111, wt all 0, o_r=1, i_h=0 -> o_s sequence 1000,0100,0010,0001,1000; i_r tracks o_s.
2. i_v=1111, wt={2,0,0,1} -> winners 0,0,0,1,2,3,3,0,0,0.
3. Way 1 only valid, wt=0, i_h=1 for 2 beats then 0; ways 2/3 assert i_v from the 2nd beat -> way 1 wins 3 beats with o_h=1,1,0 and i_r[2:3]=0 throughout; way 2 wins the 4th beat.
4. Lock held by way 0, then i_v[0] drops while i_v[2]=1 -> o_v=0, o_s=0000 until way 0 returns; way 0 beat with i_h=0 is accepted, then way 2 is granted.
5. o_r=0 for 5 cycles with i_v=0110 -> o_v=1, o_s=0100 constant, i_r=0000, cnt/g unchanged; the first o_r=1 accepts way 1.
6. reset pulsed while way 3 locked, i_v=1111 -> cycle after reset: o_s=1000, lck=0.
